// File: rtl/gyro_pkg.sv
// Shared types and constants for the gyro pulse-torque sequencer.
// The overrun flag is built only when GYTQ_OVERRUN_EN is defined.
package gyro_pkg;

  localparam int CNT_W_DEFAULT = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_TORQUE = 2'd2,
    ST_RESET  = 2'd3
  } gy_state_e;

  localparam logic [1:0] AX_ILL = 2'b00;
  localparam logic [1:0] AX_X   = 2'b01;
  localparam logic [1:0] AX_Y   = 2'b10;
  localparam logic [1:0] AX_Z   = 2'b11;

  // Drive vector bit order: {XP, XM, YP, YM, ZP, ZM}
  function automatic logic [5:0] axis_drive(input logic [1:0] axis, input logic sign);
    logic [5:0] d;
    d = 6'b000000;
    case (axis)
      AX_X:    d = sign ? 6'b010000 : 6'b100000;
      AX_Y:    d = sign ? 6'b000100 : 6'b001000;
      AX_Z:    d = sign ? 6'b000001 : 6'b000010;
      default: d = 6'b000000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gyro_strobe_counter.sv
// Counts pace strobes while enabled and flags the strobe that reaches the
// programmed terminal count; cleared whenever the sequencer changes state.
module gyro_strobe_counter
  import gyro_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_pace,
  input  logic [CW-1:0] i_term,
  output logic          o_tick
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en & i_pace & (r_cnt == (i_term - ONE));

  // Strobe count: clear on state change, advance on each enabled strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en && i_pace) begin
      r_cnt <= r_cnt + ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/gyro_torque_sequencer.sv
// Gyro pulse-torque sequencer: SETUP -> TORQUE -> RESET paced by the scaler.
// Optional sticky overrun flag is enabled with GYTQ_OVERRUN_EN.
module gyro_torque_sequencer
  import gyro_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter int SETUP_STROBES = 2,
  parameter int RESET_STROBES = 2
) (
  input  logic             CLOCK,
  input  logic             rst_,
  input  logic             PACE,
  input  logic             GOJAM,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_axis,
  input  logic             cmd_sign,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             GYENAB,
  output logic             GYXP,
  output logic             GYXM,
  output logic             GYYP,
  output logic             GYYM,
  output logic             GYZP,
  output logic             GYZM,
  output logic             GYRSET,
  output logic             GYRRST,
  output logic             GYROD,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             cmd_err,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [3:0]       SETUP_TERM = 4'(SETUP_STROBES);
  localparam logic [3:0]       RESET_TERM = 4'(RESET_STROBES);
  localparam logic [CNT_W-1:0] REM_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] REM_ZERO   = CNT_W'(0);

  gy_state_e        r_state, w_next_state;
  logic [5:0]       r_drv, w_drv_nxt;
  logic [CNT_W-1:0] r_remaining, w_rem_nxt;
  logic             r_done, w_done_nxt;
  logic             r_cmd_err, w_err_nxt;
  logic             w_tick;
  logic             w_cnt_en;
  logic [3:0]       w_term;
  logic             w_state_chg;

  assign w_cnt_en    = (r_state == ST_SETUP) | (r_state == ST_RESET);
  assign w_term      = (r_state == ST_SETUP) ? SETUP_TERM : RESET_TERM;
  assign w_state_chg = (w_next_state != r_state);

  gyro_strobe_counter #(.CW(4)) u_strobe_cnt (
    .i_clk   (CLOCK),
    .i_rst_n (rst_),
    .i_clr   (w_state_chg),
    .i_en    (w_cnt_en),
    .i_pace  (PACE),
    .i_term  (w_term),
    .o_tick  (w_tick)
  );

  // Next-state and next-register values; GOJAM overrides everything
  always_comb begin
    w_next_state = r_state;
    w_drv_nxt    = r_drv;
    w_rem_nxt    = r_remaining;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    if (GOJAM) begin
      w_next_state = ST_IDLE;
      w_drv_nxt    = 6'b000000;
      w_rem_nxt    = REM_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && (cmd_axis == AX_ILL)) begin
            w_err_nxt = 1'b1;
          end else if (cmd_valid) begin
            w_next_state = ST_SETUP;
            w_drv_nxt    = axis_drive(cmd_axis, cmd_sign);
            w_rem_nxt    = cmd_count;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            w_next_state = (r_remaining != REM_ZERO) ? ST_TORQUE : ST_RESET;
          end else begin
            w_next_state = ST_SETUP;
          end
        end
        ST_TORQUE: begin
          if (PACE && (r_remaining > REM_ONE)) begin
            w_rem_nxt = r_remaining - REM_ONE;
          end else if (PACE) begin
            w_rem_nxt    = REM_ZERO;
            w_next_state = ST_RESET;
          end else begin
            w_next_state = ST_TORQUE;
          end
        end
        ST_RESET: begin
          if (w_tick) begin
            w_next_state = ST_IDLE;
            w_drv_nxt    = 6'b000000;
            w_done_nxt   = 1'b1;
          end else begin
            w_next_state = ST_RESET;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_drv_nxt    = 6'b000000;
          w_rem_nxt    = REM_ZERO;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath registers: drives, pulse count and one-cycle status pulses
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      r_drv       <= 6'b000000;
      r_remaining <= REM_ZERO;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_drv       <= w_drv_nxt;
      r_remaining <= w_rem_nxt;
      r_done      <= w_done_nxt;
      r_cmd_err   <= w_err_nxt;
    end
  end

`ifdef GYTQ_OVERRUN_EN
  logic r_overrun;

  // Sticky overrun; a new event wins over a simultaneous clear
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      r_overrun <= 1'b0;
    end else if (cmd_valid && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign overrun = r_overrun;
`else
  logic w_unused_ovr_clr;
  assign w_unused_ovr_clr = ovr_clr;
  assign overrun          = 1'b0;
`endif

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign GYENAB    = (r_state != ST_IDLE);
  assign GYRSET    = (r_state == ST_SETUP);
  assign GYRRST    = (r_state == ST_RESET);
  // The torque pulse is the pace strobe itself, suppressed by a coincident restart
  assign GYROD     = (r_state == ST_TORQUE) & PACE & ~GOJAM;
  assign remaining = r_remaining;
  assign done      = r_done;
  assign cmd_err   = r_cmd_err;
  assign {GYXP, GYXM, GYYP, GYYM, GYZP, GYZM} = r_drv;

endmodule

// File: doc/gyro_torque_sequencer.md
Name: gyro_torque_sequencer

Overview:
- Sequences the gyro pulse-torquing outputs of the inout-channel logic: GYENAB, the six axis/sign drives GYXP..GYZM, GYRSET, GYRRST and GYROD.
- A command (axis, sign, pulse count) is accepted from the channel-14 write path. The block then runs set-up, torque and reset phases, all paced by a scaler strobe.
- Sits between the channel-14 write decode and the gyro drive buffers. It is the only block that drives those outputs.

Parameters:
- CNT_W, 11, width of the pulse-count field (channel-14 bits 1-11)
- SETUP_STROBES, 2, pace strobes spent in SETUP with GYRSET high
- RESET_STROBES, 2, pace strobes spent in RESET with GYRRST high

Ports:
- CLOCK  in  1  system clock; all state updates on its rising edge
- rst_  in  1  asynchronous, active-low reset
- PACE  in  1  one-cycle pace strobe from the scaler (3200 pps nominal)
- GOJAM  in  1  restart; synchronous abort, highest priority
- cmd_valid  in  1  command offered; derived from WCH14
- cmd_ready  out  1  high only in IDLE
- cmd_axis  in  2  01=X, 10=Y, 11=Z, 00=illegal
- cmd_sign  in  1  0=plus, 1=minus
- cmd_count  in  CNT_W  number of torque pulses
- GYENAB  out  1  gyro enable; high in SETUP, TORQUE and RESET
- GYXP, GYXM, GYYP, GYYM, GYZP, GYZM  out  1 each  latched axis/sign select; at most one high
- GYRSET  out  1  high throughout SETUP
- GYRRST  out  1  high throughout RESET
- GYROD  out  1  one-cycle torque pulse
- busy  out  1  high whenever not IDLE
- remaining  out  CNT_W  pulses still to emit
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle pulse when an illegal axis is accepted
- overrun  out  1  sticky overrun flag (optional feature)
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset values (rst_ low, asynchronous): state IDLE, every output 0, except cmd_ready=1. The strobe counter and remaining are 0.
- States: IDLE, SETUP, TORQUE, RESET.
- Command acceptance: occurs on a cycle with cmd_valid & cmd_ready.
  - Legal axis: latch the axis/sign drive, set remaining=cmd_count, clear the strobe counter, enter SETUP on the next cycle.
  - Illegal axis (00): stay in IDLE and pulse cmd_err for one cycle. done stays 0.
- SETUP: GYRSET=1. Count PACE strobes. On the SETUP_STROBES-th strobe:
  - go to TORQUE if remaining≠0;
  - otherwise go directly to RESET.
- TORQUE: on each PACE strobe, GYROD=1 for that same cycle (combinational from state & PACE) and remaining decrements.
  - The strobe that takes remaining from 1 to 0 emits its pulse and transitions to RESET.
  - No wrap-around: remaining never goes below 0.
- RESET: GYRRST=1. On the RESET_STROBES-th strobe, enter IDLE, pulse done for one cycle and clear the axis drives.
- Axis/sign drive outputs are held constant from acceptance until IDLE is re-entered.
- Strobe-counter rule: a PACE strobe on the cycle a state is entered is not counted toward that state. PACE on the acceptance cycle is ignored.
- GOJAM: in any state, on the next edge go to IDLE with all drives, GYRSET, GYRRST and remaining cleared. done is not pulsed. GOJAM in IDLE blocks acceptance that cycle.
- Simultaneous events: GOJAM beats PACE, which beats cmd_valid.
- Total command latency, acceptance to done: SETUP_STROBES+count+RESET_STROBES strobes.

Optional Feature:
- Macro GYTQ_OVERRUN_EN.
- Defined: cmd_valid high while busy sets overrun, which stays set until ovr_clr or reset. If ovr_clr and a new overrun event occur together, set wins. The offered command is still ignored.
- Undefined: overrun is tied 0, ovr_clr is ignored, and no flop is generated.

Decomposition:
- Shared package gyro_pkg holds:
  - state enum (IDLE, SETUP, TORQUE, RESET);
  - axis codes AX_ILL/AX_X/AX_Y/AX_Z;
  - default CNT_W.
- One sub-module, gyro_strobe_counter: counts PACE strobes up to a programmable terminal value, clears on state entry, and outputs a terminal pulse. It is used for both SETUP and RESET.

Test Plan:
- Reset with rst_ low mid-TORQUE (count 5, 2 emitted) -> all outputs 0 at once, cmd_ready=1.
- Command X+, count 3, default params -> GYXP high. Timeline:
  - GYRSET for strobes 1-2;
  - GYROD on strobes 3, 4, 5, with remaining 3→2→1→0;
  - GYRRST on strobes 6-7;
  - done one cycle after strobe 7.
- Command Z-, count 0 -> GYZM held; SETUP 2 strobes, then RESET 2 strobes; zero GYROD pulses; done after 4th strobe.
- Axis 00, count 7 -> cmd_err one cycle; state stays IDLE; no GYENAB; done=0.
- GOJAM during TORQUE of a Y+ count-10 command after 4 pulses, coincident with PACE -> no GYROD that cycle, IDLE next edge, remaining=0, done=0.
- GYTQ_OVERRUN_EN: cmd_valid while busy -> overrun=1 and the running command completes unchanged. ovr_clr -> overrun=0. Without the macro, overrun stays 0.
